// File: rtl/nibble_field_sched.sv
// nibble_field_sched: round-robin scheduler that owns a wide field register and
// runs one nibble read-modify-write per grant, returning the pre-write bits.
// Nibble positions use indexed part-select semantics (+: / -:) without wrap;
// positions outside [MSB:LSB] are never written and read back as 0.
// Optional build macro: NIBBLE_FIELD_SCHED_STATS_EN enables saturating
// op/truncation counters; otherwise stat_ops/stat_trunc are tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | offer grant to next valid requester after rr pointer
// ACCESS | compute bit positions, capture old bits and truncation
// COMMIT | write in-range bits of the nibble (write ops only)
// RESP   | hold response until rsp_ready
module nibble_field_sched #(
    parameter int MSB  = 83,
    parameter int LSB  = 4,
    parameter int NW   = 4,
    parameter int IDXW = 7,
    parameter int NREQ = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic [MSB-LSB:0]          load_data,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_write,
    input  logic [NREQ-1:0]           req_down,
    input  logic [NREQ*IDXW-1:0]      req_idx,
    input  logic [NREQ*NW-1:0]        req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [NW-1:0]             rsp_rdata,
    output logic                      rsp_trunc,
    output logic [MSB:LSB]            field_q,
    output logic [15:0]               stat_ops,
    output logic [15:0]               stat_trunc
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = IDXW + 2;
    typedef logic signed [PW-1:0] pos_t;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]      state_q;
    logic [IDW-1:0]  rr_q;
    logic [IDW-1:0]  id_q;
    logic            write_q;
    logic            down_q;
    logic [IDXW-1:0] idx_q;
    logic [NW-1:0]   wdata_q;
    logic [NW-1:0]   rdata_q;
    logic            trunc_q;

    logic [NREQ-1:0] gnt;
    logic            found;
    logic [IDW-1:0]  sel_id;
    logic            sel_write;
    logic            sel_down;
    logic [IDXW-1:0] sel_idx;
    logic [NW-1:0]   sel_wdata;

    pos_t            pos [NW];
    logic [NW-1:0]   in_rng;
    logic [NW-1:0]   rd_n;
    logic            trunc_n;
    logic [MSB:LSB]  field_n;

    // Round-robin pick: first valid requester after the last granted one.
    always_comb begin
        gnt       = '0;
        found     = 1'b0;
        sel_id    = '0;
        sel_write = 1'b0;
        sel_down  = 1'b0;
        sel_idx   = '0;
        sel_wdata = '0;
        for (int d = 0; d < NREQ; d++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (i == ((int'(rr_q) + 1 + d) % NREQ))) begin
                    found     = 1'b1;
                    gnt[i]    = 1'b1;
                    sel_id    = IDW'(i);
                    sel_write = req_write[i];
                    sel_down  = req_down[i];
                    sel_idx   = req_idx[i*IDXW +: IDXW];
                    sel_wdata = req_wdata[i*NW +: NW];
                end
            end
        end
    end

    assign req_ready = (state_q == S_IDLE) ? gnt : '0;

    // Signed bit positions of the latched nibble; no wrap, so range is checked per bit.
    always_comb begin
        for (int k = 0; k < NW; k++) begin
            if (down_q)
                pos[k] = pos_t'({2'b00, idx_q}) - pos_t'(NW - 1) + pos_t'(k);
            else
                pos[k] = pos_t'({2'b00, idx_q}) + pos_t'(k);
            in_rng[k] = (int'(pos[k]) >= LSB) && (int'(pos[k]) <= MSB);
        end
    end

    // Old-data read: out-of-range positions read as 0 and flag truncation.
    always_comb begin
        rd_n    = '0;
        trunc_n = 1'b0;
        for (int k = 0; k < NW; k++) begin
            if (!in_rng[k])
                trunc_n = 1'b1;
            for (int b = LSB; b <= MSB; b++) begin
                if (in_rng[k] && (int'(pos[k]) == b))
                    rd_n[k] = field_q[b];
            end
        end
    end

    // Next field value: whole-field load first, committed nibble bits overlay it.
    always_comb begin
        field_n = load_en ? load_data : field_q;
        if ((state_q == S_COMMIT) && write_q) begin
            for (int k = 0; k < NW; k++) begin
                for (int b = LSB; b <= MSB; b++) begin
                    if (in_rng[k] && (int'(pos[k]) == b))
                        field_n[b] = wdata_q[k];
                end
            end
        end
    end

    // Field register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            field_q <= '0;
        else
            field_q <= field_n;
    end

    // Operation sequencer and request latch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= IDW'(NREQ - 1);
            id_q    <= '0;
            write_q <= 1'b0;
            down_q  <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        id_q    <= sel_id;
                        write_q <= sel_write;
                        down_q  <= sel_down;
                        idx_q   <= sel_idx;
                        wdata_q <= sel_wdata;
                        rr_q    <= sel_id;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rdata_q <= rd_n;
                    trunc_q <= trunc_n;
                    state_q <= S_COMMIT;
                end
                S_COMMIT: begin
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready)
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_id    = id_q;
    assign rsp_rdata = rdata_q;
    assign rsp_trunc = trunc_q;

`ifdef NIBBLE_FIELD_SCHED_STATS_EN
    logic [15:0] ops_q;
    logic [15:0] trc_q;

    // Saturating counters advanced on each accepted response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops_q <= '0;
            trc_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (ops_q != 16'hFFFF)
                ops_q <= ops_q + 16'd1;
            if (trunc_q && (trc_q != 16'hFFFF))
                trc_q <= trc_q + 16'd1;
        end
    end

    assign stat_ops   = ops_q;
    assign stat_trunc = trc_q;
`else
    assign stat_ops   = 16'h0;
    assign stat_trunc = 16'h0;
`endif

endmodule

// File: tb/tb_nibble_field_sched.sv
// Self-checking bench for nibble_field_sched: scoreboard of expected responses
// pushed at each grant and popped when the response is accepted.
module tb_nibble_field_sched;

    localparam int MSB  = 83;
    localparam int LSB  = 4;
    localparam int NW   = 4;
    localparam int IDXW = 7;
    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 load_en;
    logic [MSB-LSB:0]     load_data;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_write;
    logic [NREQ-1:0]      req_down;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ*NW-1:0]   req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [0:0]           rsp_id;
    logic [NW-1:0]        rsp_rdata;
    logic                 rsp_trunc;
    logic [MSB:LSB]       field_q;
    logic [15:0]          stat_ops;
    logic [15:0]          stat_trunc;

    nibble_field_sched dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_data  (load_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_down   (req_down),
        .req_idx    (req_idx),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .rsp_trunc  (rsp_trunc),
        .field_q    (field_q),
        .stat_ops   (stat_ops),
        .stat_trunc (stat_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [3:0] rd;
        logic       tr;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    logic [MSB:LSB] mdl;
    int             n_tests = 0;
    int             n_fail  = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of one nibble access on mdl.
    task automatic model_op(input bit wr, input bit dn, input int idx, input logic [3:0] wd,
                            output logic [3:0] rd, output logic tr);
        int p;
        rd = '0;
        tr = 1'b0;
        for (int k = 0; k < NW; k++) begin
            p = dn ? idx - (NW - 1) + k : idx + k;
            if (p >= LSB && p <= MSB) begin
                rd[k] = mdl[p];
                if (wr) mdl[p] = wd[k];
            end else begin
                tr = 1'b1;
            end
        end
    endtask

    task automatic push_exp(input int id, input bit wr, input bit dn, input int idx, input logic [3:0] wd);
        exp_t e;
        logic [3:0] rd;
        logic tr;
        model_op(wr, dn, idx, wd, rd, tr);
        e.id = id;
        e.rd = rd;
        e.tr = tr;
        sb.push_back(e);
    endtask

    task automatic set_req(input int id, input bit wr, input bit dn, input int idx, input logic [3:0] wd);
        req_write[id]              = wr;
        req_down[id]               = dn;
        req_idx[id*IDXW +: IDXW]   = IDXW'(idx);
        req_wdata[id*NW +: NW]     = wd;
    endtask

    // Drive one request, wait for its grant, record the expectation; returns just after the handshake edge.
    task automatic issue(input int id, input bit wr, input bit dn, input int idx, input logic [3:0] wd);
        bit ok;
        @(posedge clk); #1;
        set_req(id, wr, dn, idx, wd);
        req_valid[id] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        if (!ok) begin
            check_val("grant_timeout", 128'(req_ready[id]), 128'(1));
            req_valid[id] = 1'b0;
            return;
        end
        push_exp(id, wr, dn, idx, wd);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        check_val("drain", 128'(sb.size()), 128'(0));
    endtask

    task automatic load(input logic [MSB-LSB:0] v);
        @(posedge clk); #1;
        load_en   = 1'b1;
        load_data = v;
        @(posedge clk); #1;
        load_en   = 1'b0;
        mdl       = v;
    endtask

    // Response checker: pops the scoreboard on each accepted response.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_val("rsp_unexpected", 128'(rsp_valid), 128'(0));
            end else begin
                mon_e = sb.pop_front();
                check_val("rsp_id", 128'(rsp_id), 128'(mon_e.id));
                check_val("rsp_rdata", 128'(rsp_rdata), 128'(mon_e.rd));
                check_val("rsp_trunc", 128'(rsp_trunc), 128'(mon_e.tr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int cyc;
        int last_cyc;
        int gid;
        int t4_idx[2];
        bit t4_dn[2];

        reset     = 1'b1;
        load_en   = 1'b0;
        load_data = '0;
        req_valid = '0;
        req_write = '0;
        req_down  = '0;
        req_idx   = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        mdl       = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_field", 128'(field_q), 128'(0));
        check_val("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check_val("rst_req_ready", 128'(req_ready), 128'(0));
        check_val("rst_rsp_id", 128'(rsp_id), 128'(0));
        check_val("rst_rsp_rdata", 128'(rsp_rdata), 128'(0));
        check_val("rst_rsp_trunc", 128'(rsp_trunc), 128'(0));
        check_val("rst_stat_ops", 128'(stat_ops), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: reads in both directions
        load(80'h7bea9d779b67e48f67da);
        issue(0, 1'b0, 1'b0, 7, 4'h0);
        drain();
        issue(0, 1'b0, 1'b1, 7, 4'h0);
        drain();
        check_val("t1_field_unchanged", 128'(field_q), 128'(mdl));

        // 2: nibble write
        load(80'hefddce326b11ca5dc448);
        issue(0, 1'b1, 1'b0, 8, 4'h1);
        drain();
        check_val("t2_xor", 128'(field_q ^ 80'hefddce326b11ca5dc448), 128'(80'h50));

        // 3: truncation at the top and bottom of the field
        load('0);
        issue(0, 1'b1, 1'b0, 83, 4'hF);
        drain();
        check_val("t3_top_bit", 128'(field_q), 128'({1'b1, 79'b0}));
        issue(0, 1'b0, 1'b0, 127, 4'h0);
        drain();
        check_val("t3_far_unchanged", 128'(field_q), 128'({1'b1, 79'b0}));
        issue(1, 1'b1, 1'b1, 5, 4'hF);
        drain();
        check_val("t3_low_write", 128'(field_q), 128'(mdl));

        // 4: both requesters continuously valid
        load(80'h0123456789abcdef0123);
        t4_idx[0] = 10; t4_dn[0] = 1'b0;
        t4_idx[1] = 40; t4_dn[1] = 1'b1;
        @(posedge clk); #1;
        set_req(0, 1'b0, t4_dn[0], t4_idx[0], 4'h0);
        set_req(1, 1'b0, t4_dn[1], t4_idx[1], 4'h0);
        req_valid = 2'b11;
        g = 0; cyc = 0; last_cyc = 0;
        for (int n = 0; n < 40 && g < 4; n++) begin
            @(negedge clk);
            cyc++;
            if (|(req_ready & req_valid)) begin
                gid = req_ready[1] ? 1 : 0;
                check_val("t4_onehot", 128'($countones(req_ready)), 128'(1));
                check_val("t4_order", 128'(gid), 128'(g % 2));
                if (g > 0) check_val("t4_spacing", 128'(cyc - last_cyc), 128'(4));
                last_cyc = cyc;
                push_exp(gid, 1'b0, t4_dn[gid], t4_idx[gid], 4'h0);
                g++;
            end
        end
        if (g < 4) check_val("t4_grants", 128'(g), 128'(4));
        @(posedge clk); #1;
        req_valid = '0;
        drain();

        // 5: response backpressure, then load colliding with commit
        rsp_ready = 1'b0;
        issue(0, 1'b0, 1'b0, 12, 4'h0);
        set_req(1, 1'b0, 1'b0, 30, 4'h0);
        req_valid[1] = 1'b1;
        for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check_val("t5_hold_valid", 128'(rsp_valid), 128'(1));
            check_val("t5_hold_rdata", 128'(rsp_rdata), 128'(sb[0].rd));
            check_val("t5_hold_id", 128'(rsp_id), 128'(sb[0].id));
            check_val("t5_no_grant", 128'(req_ready), 128'(0));
        end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rsp_ready    = 1'b1;
        drain();
        issue(0, 1'b1, 1'b0, 20, 4'hA);
        @(posedge clk); #1;
        load_en   = 1'b1;
        load_data = 80'hffffffffffffffffffff;
        @(posedge clk); #1;
        load_en   = 1'b0;
        mdl       = 80'hffffffffffffffffffff;
        mdl[23:20] = 4'hA;
        check_val("t5_commit_wins", 128'(field_q), 128'(mdl));
        drain();

        // 6: reset during COMMIT, then statistics
        load(80'h13579bdf02468ace1357);
        issue(0, 1'b1, 1'b0, 40, 4'h5);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_val("t6_field_cleared", 128'(field_q), 128'(0));
        check_val("t6_rsp_dropped", 128'(rsp_valid), 128'(0));
        sb.delete();
        mdl = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_val("t6_no_rsp", 128'(rsp_valid), 128'(0));
        check_val("t6_no_write", 128'(field_q), 128'(0));
        issue(0, 1'b0, 1'b0, 10, 4'h0);
        drain();
        issue(0, 1'b1, 1'b0, 83, 4'hF);
        drain();
        issue(1, 1'b0, 1'b0, 50, 4'h0);
        drain();
`ifdef NIBBLE_FIELD_SCHED_STATS_EN
        check_val("t6_stat_ops", 128'(stat_ops), 128'(3));
        check_val("t6_stat_trunc", 128'(stat_trunc), 128'(1));
`else
        check_val("t6_stat_ops_off", 128'(stat_ops), 128'(0));
        check_val("t6_stat_trunc_off", 128'(stat_trunc), 128'(0));
`endif
        check_val("t6_field_final", 128'(field_q), 128'(mdl));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
